// File: rtl/arb_pkg.sv
// Shared types and helpers for the grant scheduler and its arbiter.
package arb_pkg;

    // Scheduler states: waiting for requests, or a grant is held.
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    // Widest requester vector the one-hot helper supports.
    localparam int MAX_N     = 64;
    localparam int MAX_SEL_W = 6;

    // One-hot decode of a source index; callers truncate to their own N.
    function automatic logic [MAX_N-1:0] onehot(input logic [MAX_SEL_W-1:0] sel);
        onehot = 64'd1 << sel;
    endfunction

endpackage

// File: rtl/priority_arbiter.sv
// Combinational priority picker: lowest priority value wins, ties go to the
// higher source index.
module priority_arbiter #(
    parameter int N         = 8,
    parameter int PRIO_BITS = 3,
    parameter int SEL_W     = $clog2(N)
) (
    input  logic [N-1:0]           req_i,
    input  logic [N*PRIO_BITS-1:0] prio_i,
    output logic                   valid_o,
    output logic [SEL_W-1:0]       sel_o,
    output logic [PRIO_BITS-1:0]   prio_o
);

    logic                 found_s;
    logic [SEL_W-1:0]     best_sel_s;
    logic [PRIO_BITS-1:0] best_prio_s;
    logic                 take_s;

    // Ascending scan with "<=" so a later (higher) index wins on equal priority.
    always_comb begin
        found_s     = 1'b0;
        best_sel_s  = '0;
        best_prio_s = '0;
        take_s      = 1'b0;
        for (int k = 0; k < N; k++) begin
            take_s      = req_i[k] &&
                          (!found_s || (prio_i[k*PRIO_BITS +: PRIO_BITS] <= best_prio_s));
            best_sel_s  = take_s ? SEL_W'(k) : best_sel_s;
            best_prio_s = take_s ? prio_i[k*PRIO_BITS +: PRIO_BITS] : best_prio_s;
            found_s     = found_s | take_s;
        end
    end

    assign valid_o = found_s;
    assign sel_o   = best_sel_s;
    assign prio_o  = best_prio_s;

endmodule

// File: rtl/arb_grant_sched.sv
// Registered grant scheduler: latches the arbitration winner, holds the grant
// until release or hold timeout, and ages losing requesters against starvation.
module arb_grant_sched
    import arb_pkg::*;
#(
    parameter int N         = 8,
    parameter int PRIO_BITS = 3,
    parameter int AGE_LIMIT = 7,
    parameter int MAX_HOLD  = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic [N-1:0]           req_i,
    input  logic [N*PRIO_BITS-1:0] prio_i,
    output logic [N-1:0]           gnt_o,
    output logic [$clog2(N)-1:0]   gnt_sel_o,
    output logic [PRIO_BITS-1:0]   gnt_prio_o,
    output logic                   busy_o,
    output logic                   preempt_o
);

    localparam int SEL_W  = $clog2(N);
    localparam int AGE_W  = (AGE_LIMIT > 0) ? $clog2(AGE_LIMIT + 1) : 1;
    localparam int HOLD_W = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam logic [AGE_W-1:0]  AGE_MAX  = AGE_W'(AGE_LIMIT);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);
    localparam logic [HOLD_W-1:0] HOLD_SAT = {HOLD_W{1'b1}};

    state_e               state_q, state_d;
    logic [N-1:0]         gnt_q, gnt_d;
    logic [SEL_W-1:0]     sel_q, sel_d;
    logic [PRIO_BITS-1:0] prio_q, prio_d;
    logic                 busy_q, busy_d;
    logic                 preempt_q, preempt_d;
    logic [HOLD_W-1:0]    hold_q, hold_d;
    logic [AGE_W-1:0]     age_q [N];
    logic [AGE_W-1:0]     age_d [N];

    logic [N*PRIO_BITS-1:0] eff_prio_s;
    logic                   win_valid_s;
    logic [SEL_W-1:0]       win_sel_s;
    logic [PRIO_BITS-1:0]   win_prio_s;
    logic [N-1:0]           win_oh_s;

    // Sources that reached the age limit are promoted to priority 0.
    always_comb begin
        eff_prio_s = '0;
        for (int k = 0; k < N; k++) begin
            eff_prio_s[k*PRIO_BITS +: PRIO_BITS] =
                ((AGE_LIMIT != 0) && (age_q[k] == AGE_MAX)) ? {PRIO_BITS{1'b0}}
                                                            : prio_i[k*PRIO_BITS +: PRIO_BITS];
        end
    end

    priority_arbiter #(
        .N         (N),
        .PRIO_BITS (PRIO_BITS),
        .SEL_W     (SEL_W)
    ) u_arb (
        .req_i   (req_i),
        .prio_i  (eff_prio_s),
        .valid_o (win_valid_s),
        .sel_o   (win_sel_s),
        .prio_o  (win_prio_s)
    );

    assign win_oh_s = N'(onehot(MAX_SEL_W'(win_sel_s)));

    // Next-state logic: grant decision, release/timeout, hold counter and aging.
    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        sel_d     = sel_q;
        prio_d    = prio_q;
        busy_d    = busy_q;
        preempt_d = 1'b0;
        hold_d    = hold_q;
        // A source that is not requesting loses any accumulated age.
        for (int k = 0; k < N; k++) begin
            age_d[k] = req_i[k] ? age_q[k] : {AGE_W{1'b0}};
        end
        case (state_q)
            IDLE: begin
                if (win_valid_s) begin
                    state_d = GRANT;
                    gnt_d   = win_oh_s;
                    sel_d   = win_sel_s;
                    prio_d  = win_prio_s;
                    busy_d  = 1'b1;
                    hold_d  = HOLD_W'(1);
                    // Losers that keep requesting age (saturating); the winner restarts.
                    for (int k = 0; k < N; k++) begin
                        age_d[k] = (SEL_W'(k) == win_sel_s) ? {AGE_W{1'b0}} :
                                   !req_i[k]                ? {AGE_W{1'b0}} :
                                   (age_q[k] == AGE_MAX)    ? AGE_MAX
                                                            : age_q[k] + AGE_W'(1);
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            GRANT: begin
                if (!req_i[sel_q]) begin
                    // Owner let go: normal release, one turnaround cycle in IDLE.
                    state_d = IDLE;
                    gnt_d   = '0;
                    busy_d  = 1'b0;
                    hold_d  = '0;
                end else if ((MAX_HOLD != 0) && (hold_q == HOLD_MAX)) begin
                    // Timeout: force release and boost the evicted owner.
                    state_d       = IDLE;
                    gnt_d         = '0;
                    busy_d        = 1'b0;
                    hold_d        = '0;
                    preempt_d     = 1'b1;
                    age_d[sel_q]  = AGE_MAX;
                end else begin
                    hold_d = (hold_q == HOLD_SAT) ? hold_q : hold_q + HOLD_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
                busy_d  = 1'b0;
                hold_d  = '0;
            end
        endcase
    end

    // State, grant, hold and age registers with asynchronous reset.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            sel_q     <= '0;
            prio_q    <= '0;
            busy_q    <= 1'b0;
            preempt_q <= 1'b0;
            hold_q    <= '0;
            for (int k = 0; k < N; k++) begin
                age_q[k] <= '0;
            end
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            sel_q     <= sel_d;
            prio_q    <= prio_d;
            busy_q    <= busy_d;
            preempt_q <= preempt_d;
            hold_q    <= hold_d;
            for (int k = 0; k < N; k++) begin
                age_q[k] <= age_d[k];
            end
        end
    end

    assign gnt_o      = gnt_q;
    assign gnt_sel_o  = sel_q;
    assign gnt_prio_o = prio_q;
    assign busy_o     = busy_q;
    assign preempt_o  = preempt_q;

endmodule

// File: tb/tb_arb_grant_sched.sv
// Randomized bench for arb_grant_sched against a cycle-level behavioural model.
module tb_arb_grant_sched;

    localparam int N  = 4;
    localparam int PB = 3;
    localparam int AL = 2;
    localparam int MH = 4;

    logic          clk_i;
    logic          rst_n_i;
    logic [N-1:0]  req_i;
    logic [N*PB-1:0] prio_i;
    logic [N-1:0]  gnt_o;
    logic [1:0]    gnt_sel_o;
    logic [PB-1:0] gnt_prio_o;
    logic          busy_o;
    logic          preempt_o;

    int n_vec;
    int n_err;

    // Model state: owner index (-1 = idle), cycles held, ages, latched grant info.
    int m_owner;
    int m_hold;
    int m_age [N];
    int m_sel;
    int m_prio;
    int m_pre;

    arb_grant_sched #(
        .N         (N),
        .PRIO_BITS (PB),
        .AGE_LIMIT (AL),
        .MAX_HOLD  (MH)
    ) dut (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .req_i      (req_i),
        .prio_i     (prio_i),
        .gnt_o      (gnt_o),
        .gnt_sel_o  (gnt_sel_o),
        .gnt_prio_o (gnt_prio_o),
        .busy_o     (busy_o),
        .preempt_o  (preempt_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_hold  = 0;
        m_sel   = 0;
        m_prio  = 0;
        m_pre   = 0;
        for (int k = 0; k < N; k++) m_age[k] = 0;
    endtask

    // Advance the model by one clock given the inputs seen at that edge.
    task automatic model_step(input logic [N-1:0] req, input logic [N*PB-1:0] prio);
        int na [N];
        int w;
        int best;
        int e;
        for (int k = 0; k < N; k++) na[k] = req[k] ? m_age[k] : 0;
        m_pre = 0;
        if (m_owner < 0) begin
            w = -1;
            best = 0;
            for (int k = 0; k < N; k++) begin
                if (req[k]) begin
                    e = (m_age[k] == AL) ? 0 : int'(prio[k*PB +: PB]);
                    if (w < 0 || e <= best) begin
                        w = k;
                        best = e;
                    end
                end
            end
            if (w >= 0) begin
                for (int k = 0; k < N; k++) begin
                    if (k == w) na[k] = 0;
                    else if (req[k]) na[k] = (m_age[k] + 1 > AL) ? AL : m_age[k] + 1;
                end
                m_owner = w;
                m_sel   = w;
                m_prio  = best;
                m_hold  = 1;
            end
        end else if (!req[m_owner]) begin
            m_owner = -1;
            m_hold  = 0;
        end else if (m_hold == MH) begin
            na[m_owner] = AL;
            m_owner = -1;
            m_hold  = 0;
            m_pre   = 1;
        end else begin
            m_hold++;
        end
        for (int k = 0; k < N; k++) m_age[k] = na[k];
    endtask

    task automatic compare_outputs();
        check_eq("gnt",     32'(gnt_o),     (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
        check_eq("busy",    32'(busy_o),    (m_owner >= 0) ? 32'd1 : 32'd0);
        check_eq("preempt", 32'(preempt_o), 32'(m_pre));
        if (m_owner >= 0) begin
            check_eq("gnt_sel",  32'(gnt_sel_o),  32'(m_sel));
            check_eq("gnt_prio", 32'(gnt_prio_o), 32'(m_prio));
        end
    endtask

    initial begin
        logic [N-1:0]    req_v;
        logic [N*PB-1:0] prio_v;
        int flip_pct;
        int prio_max;
        int rst_pending;
        int phase;

        n_vec = 0;
        n_err = 0;
        rst_n_i = 1'b0;
        req_i   = '0;
        prio_i  = '0;
        req_v   = '0;
        prio_v  = '0;
        rst_pending = 0;
        model_reset();
        repeat (2) @(negedge clk_i);
        rst_n_i = 1'b1;

        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk_i);
            if (cyc % 700 == 350) rst_pending = 1;
            // Asynchronous reset while a grant is active, all requests high.
            if (rst_pending != 0 && m_owner >= 0) begin
                rst_pending = 0;
                req_v = 4'hF;
                req_i = req_v;
                #2;
                rst_n_i = 1'b0;
                #1;
                check_eq("rst_gnt",     32'(gnt_o),     32'd0);
                check_eq("rst_busy",    32'(busy_o),    32'd0);
                check_eq("rst_preempt", 32'(preempt_o), 32'd0);
                model_reset();
                @(negedge clk_i);
                rst_n_i = 1'b1;
            end
            compare_outputs();

            phase = cyc / 750;
            case (phase)
                0:       begin flip_pct = 20; prio_max = 7; end
                1:       begin flip_pct = 20; prio_max = 1; end
                2:       begin flip_pct = 6;  prio_max = 7; end
                default: begin flip_pct = 45; prio_max = 3; end
            endcase
            for (int k = 0; k < N; k++) begin
                if ($urandom_range(0, 99) < 32'(flip_pct)) req_v[k] = ~req_v[k];
                if ($urandom_range(0, 4) == 0)
                    prio_v[k*PB +: PB] = PB'($urandom_range(0, prio_max));
            end
            model_step(req_v, prio_v);
            req_i  = req_v;
            prio_i = prio_v;
        end

        @(negedge clk_i);
        compare_outputs();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
